// File: rtl/lcd_fb_pkg.sv
// Shared definitions for the LCD frame-buffer write/read sides:
// FSM state type, default display window and the frame pixel count.
package lcd_fb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_HOLD  = 2'd2
  } fb_state_e;

  localparam int unsigned DEF_START_ADDR = 108;
  localparam int unsigned DEF_END_ADDR   = 6518;
  localparam int unsigned FRAME_PIXELS   = DEF_END_ADDR - DEF_START_ADDR + 1;

endpackage

// File: rtl/lcd_fb_wr_addr_gen.sv
// Loadable write-address counter over the display window; saturates at the
// last window address and flags it.
module lcd_fb_wr_addr_gen #(
  parameter int unsigned ADDR_WIDTH = 17,
  parameter int unsigned START_ADDR = 108,
  parameter int unsigned END_ADDR   = 6518
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  load,
  input  logic                  inc,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last
);

  localparam logic [ADDR_WIDTH-1:0] FIRST = ADDR_WIDTH'(START_ADDR);
  localparam logic [ADDR_WIDTH-1:0] FINAL = ADDR_WIDTH'(END_ADDR);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr <= FIRST;
    end else if (load) begin
      addr <= FIRST;
    end else if (inc && !last) begin
      addr <= addr + ADDR_WIDTH'(1);
    end
  end

  always_comb begin
    last = (addr == FINAL);
  end

endmodule

// File: rtl/lcd_fb_writer.sv
// Write side of the LCD frame-buffer RAM: pixel stream in, RAM writes out,
// frame handed to the reader until released. LCD_FB_WR_PACK8_EN selects byte-mode input.
module lcd_fb_writer
  import lcd_fb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 17,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned START_ADDR = DEF_START_ADDR,
  parameter int unsigned END_ADDR   = DEF_END_ADDR
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic                  s_valid_i,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  output logic                  s_ready_o,
  output logic                  ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  output logic                  busy_o,
  output logic                  frame_done_o,
  output logic                  frame_ready_o,
  input  logic                  rd_stop_i
);

  fb_state_e             state;
  fb_state_e             state_nxt;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  addr_last;
  logic                  addr_load;
  logic                  beat_acc;
  logic                  pix_acc;
  logic                  pix_last;
  logic [DATA_WIDTH-1:0] pix_data;

  lcd_fb_wr_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .START_ADDR (START_ADDR),
    .END_ADDR   (END_ADDR)
  ) u_addr_gen (
    .clk  (clk),
    .rstn (rstn),
    .load (addr_load),
    .inc  (pix_acc),
    .addr (addr),
    .last (addr_last)
  );

  always_comb begin
    beat_acc  = s_valid_i && s_ready_o;
    addr_load = (state == ST_IDLE) && start_i;
  end

`ifdef LCD_FB_WR_PACK8_EN
  logic       hi_valid;
  logic [7:0] hi_byte;

  // Half pixel is dropped whenever the frame is left (abort) or not yet entered.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hi_valid <= 1'b0;
      hi_byte  <= '0;
    end else if (state != ST_WRITE || abort_i) begin
      hi_valid <= 1'b0;
    end else if (beat_acc) begin
      hi_valid <= !hi_valid;
      if (!hi_valid) begin
        hi_byte <= s_data_i[7:0];
      end
    end
  end

  always_comb begin
    pix_acc  = beat_acc && hi_valid;
    pix_data = DATA_WIDTH'({hi_byte, s_data_i[7:0]});
  end
`else
  always_comb begin
    pix_acc  = beat_acc;
    pix_data = s_data_i;
  end
`endif

  // Abort wins over completion: the beat is still written but the frame is not handed over.
  always_comb begin
    pix_last = pix_acc && addr_last && !abort_i;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (start_i) state_nxt = ST_WRITE;
      ST_WRITE: begin
        if (abort_i) begin
          state_nxt = ST_IDLE;
        end else if (pix_last) begin
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD:  if (rd_stop_i) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    s_ready_o = (state == ST_WRITE);
    busy_o    = (state != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ram_we_o      <= 1'b0;
      ram_addr_o    <= '0;
      ram_wdata_o   <= '0;
      frame_done_o  <= 1'b0;
      frame_ready_o <= 1'b0;
    end else begin
      ram_we_o     <= pix_acc;
      frame_done_o <= pix_last;
      if (pix_acc) begin
        ram_addr_o  <= addr;
        ram_wdata_o <= pix_data;
      end
      if (state == ST_HOLD && rd_stop_i) begin
        frame_ready_o <= 1'b0;
      end else if (pix_last) begin
        frame_ready_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lcd_fb_writer.sv
// Directed/randomized bench for lcd_fb_writer against a pixel-list reference model.
module tb_lcd_fb_writer;
  import lcd_fb_pkg::*;

  localparam int AW = 17;
  localparam int DW = 16;
  localparam int SA = 108;
  localparam int EA = 6518;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start_i = 1'b0;
  logic          abort_i = 1'b0;
  logic          s_valid_i = 1'b0;
  logic [DW-1:0] s_data_i = '0;
  logic          rd_stop_i = 1'b0;
  logic          s_ready_o;
  logic          ram_we_o;
  logic [AW-1:0] ram_addr_o;
  logic [DW-1:0] ram_wdata_o;
  logic          busy_o;
  logic          frame_done_o;
  logic          frame_ready_o;

  lcd_fb_writer #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .START_ADDR (SA),
    .END_ADDR   (EA)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .start_i       (start_i),
    .abort_i       (abort_i),
    .s_valid_i     (s_valid_i),
    .s_data_i      (s_data_i),
    .s_ready_o     (s_ready_o),
    .ram_we_o      (ram_we_o),
    .ram_addr_o    (ram_addr_o),
    .ram_wdata_o   (ram_wdata_o),
    .busy_o        (busy_o),
    .frame_done_o  (frame_done_o),
    .frame_ready_o (frame_ready_o),
    .rd_stop_i     (rd_stop_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          done;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t got_q[$];
  wr_t exp_q[$];
  int  n_pass  = 0;
  int  n_total = 0;
  int  pix     = 0;

  // Record every write or done pulse shortly after each active edge.
  always @(posedge clk) begin
    wr_t w;
    #1;
    if (ram_we_o || frame_done_o) begin
      w = {frame_done_o, ram_addr_o, ram_wdata_o};
      got_q.push_back(w);
    end
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    pix = 0;
  endtask

  task automatic drive_beat(input logic [DW-1:0] d, input logic ab);
    s_valid_i = 1'b1;
    s_data_i  = d;
    abort_i   = ab;
    tick();
    s_valid_i = 1'b0;
    abort_i   = 1'b0;
    s_data_i  = DW'($urandom);
  endtask

  task automatic gap(input bit thr);
    if (thr) repeat ($urandom_range(0, 2)) tick();
  endtask

  // Model: the n-th accepted pixel of a frame lands at START+n; done only on END, never on abort.
  task automatic send_pixel(input logic [DW-1:0] d, input bit thr, input bit ab);
    wr_t e;
`ifdef LCD_FB_WR_PACK8_EN
    logic [7:0] junk;
    junk = 8'($urandom);
    gap(thr);
    drive_beat({junk, d[15:8]}, 1'b0);
    gap(thr);
    drive_beat({~junk, d[7:0]}, ab);
`else
    gap(thr);
    drive_beat(d, ab);
`endif
    e.addr = AW'(SA + pix);
    e.data = d;
    e.done = ((SA + pix) == EA) && !ab;
    exp_q.push_back(e);
    pix++;
  endtask

  task automatic send_pixels(input int n, input bit thr);
    for (int i = 0; i < n; i++) send_pixel(DW'($urandom), thr, 1'b0);
  endtask

  task automatic compare_writes(input string tag);
    int errs;
    errs = 0;
    tick();
    tick();
    check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      if (got_q[i] !== exp_q[i]) errs++;
    end
    check({tag, "_content_errs"}, 64'(errs), 64'd0);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, 64'({ram_we_o, ram_addr_o, ram_wdata_o, busy_o, s_ready_o,
                    frame_done_o, frame_ready_o}), 64'd0);
  endtask

  initial begin
    tick();
    check_all_zero("reset_outputs");
    tick();
    rstn = 1'b1;
    tick();
    check("idle_busy", 64'(busy_o), 64'd0);
    check("idle_ready", 64'(s_ready_o), 64'd0);

    // Full frame, back-to-back beats
    do_start();
    check("write_ready", 64'(s_ready_o), 64'd1);
    check("write_busy", 64'(busy_o), 64'd1);
    send_pixels(FRAME_PIXELS, 1'b0);
    compare_writes("full_frame");
    check("hold_frame_ready", 64'(frame_ready_o), 64'd1);
    check("hold_ready", 64'(s_ready_o), 64'd0);
    check("hold_busy", 64'(busy_o), 64'd1);

    // HOLD ignores start and abort; rd_stop releases, coincident start ignored
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    tick();
    check("hold_keeps_busy", 64'(busy_o), 64'd1);
    check("hold_keeps_frame_ready", 64'(frame_ready_o), 64'd1);
    rd_stop_i = 1'b1;
    start_i   = 1'b1;
    tick();
    rd_stop_i = 1'b0;
    start_i   = 1'b0;
    check("release_busy", 64'(busy_o), 64'd0);
    check("release_frame_ready", 64'(frame_ready_o), 64'd0);
    tick();
    tick();
    check("release_stays_idle", 64'(busy_o), 64'd0);
    drive_beat(DW'($urandom), 1'b0);
    tick();
    check("idle_no_write", 64'(got_q.size()), 64'd0);

    // Throttled beats up to addr 499, abort together with the beat for addr 500
    do_start();
    send_pixels(500 - SA, 1'b1);
    send_pixel(DW'($urandom), 1'b1, 1'b1);
    compare_writes("abort_500");
    check("abort_busy", 64'(busy_o), 64'd0);
    check("abort_frame_ready", 64'(frame_ready_o), 64'd0);

    do_start();
    send_pixels(5, 1'b0);
    compare_writes("restart");

    // Asynchronous reset in the middle of a frame
    rstn = 1'b0;
    #1;
    check_all_zero("midframe_reset_outputs");
    tick();
    rstn = 1'b1;
    tick();
    check("post_reset_writes", 64'(got_q.size()), 64'd0);

    do_start();
    send_pixels(FRAME_PIXELS, 1'b1);
    compare_writes("throttled_frame");
    check("throttled_frame_ready", 64'(frame_ready_o), 64'd1);
    rd_stop_i = 1'b1;
    tick();
    rd_stop_i = 1'b0;
    check("throttled_release", 64'(frame_ready_o), 64'd0);

`ifdef LCD_FB_WR_PACK8_EN
    // Byte mode: half pixel dropped by abort; two bytes form one pixel
    do_start();
    drive_beat(16'hAAF8, 1'b0);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    tick();
    tick();
    check("pack_half_abort_writes", 64'(got_q.size()), 64'd0);
    do_start();
    drive_beat(16'h55F8, 1'b0);
    drive_beat(16'hC31F, 1'b0);
    tick();
    tick();
    check("pack_write_count", 64'(got_q.size()), 64'd1);
    if (got_q.size() > 0) begin
      check("pack_write_word", 64'(got_q[0]), 64'({1'b0, AW'(SA), 16'hF81F}));
    end
    got_q.delete();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
